ram_b_master: RTL and testbench
===============================

Name: ram_b_master

Overview:
- Initiator for the RAM_B-style synchronous single-port memory.
- Accepts single-word write and burst-read requests from a CPU/loader over a valid/ready handshake and drives the RAM port (address, write enable, write data).
- Captures the registered 48-bit RAM read word and checks its 16-bit tag field.
- Returns read data, or a write completion, as one-cycle response pulses.

Parameters:
- TAG, 16'h0F37, expected value of ram_douta[47:32] on a valid read.
- ADDR_W, 20, RAM address width.
- LEN_W, 5, burst length field width.

Ports:
- clka  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  master can accept a request.
- req_we  in  1  1 = single-word write, 0 = burst read.
- req_addr  in  ADDR_W  start word address.
- req_len  in  LEN_W  read burst word count; 0 is treated as 1; ignored for writes.
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_data  out  32  read word; 0 for write completions.
- rsp_err  out  1  tag mismatch on this word; always 0 for writes.
- rsp_last  out  1  final response of the request.
- busy  out  1  request in progress (equals ~req_ready).
- ram_addra  out  ADDR_W  RAM address.
- ram_wea  out  1  RAM write enable.
- ram_dina  out  32  RAM write data.
- ram_douta  in  48  registered RAM read word; tag in [47:32], data in [31:0].

Behaviour:
- Reset (async, rst_n=0) clears all outputs and state immediately:
  - req_ready=1, busy=0, rsp_valid=0, rsp_data=0, rsp_err=0, rsp_last=0.
  - ram_addra=0, ram_wea=0, ram_dina=0, state=IDLE.
  - Outstanding reads are discarded; no response is produced for them after reset release.
- States: IDLE, WR, RD_ISSUE, RD_DRAIN.
- IDLE:
  - req_ready=1.
  - On an edge with req_valid&&req_ready (accept edge E0): register ram_addra=req_addr and ram_dina=req_wdata; set req_ready=0.
  - If req_we=1: set ram_wea=1 and go to WR.
  - If req_we=0: load remaining = (req_len==0 ? 1 : req_len) and go to RD_ISSUE.
- WR:
  - RAM writes at E1.
  - At E1 the master drives ram_wea=0, rsp_valid=1, rsp_last=1, rsp_err=0, rsp_data=0, req_ready=1, and returns to IDLE.
- RD_ISSUE:
  - One address per cycle.
  - At each edge while issued count < N: increment ram_addra (mod 2^ADDR_W, wraps 0xFFFFF->0x00000).
  - After the Nth address has been presented, ram_addra holds that address; go to RD_DRAIN.
- Read pipeline:
  - Address registered at edge Ek is sampled by the RAM at Ek+1.
  - The master captures ram_douta at Ek+2.
  - A 2-deep in-flight valid/last shift register tracks this.
  - Word i of a burst accepted at E0 produces rsp_valid high in the cycle after edge E2+i.
  - rsp_data = ram_douta[31:0]; rsp_err = (ram_douta[47:32] != TAG).
- Out-of-range addresses return 48'b0 from the RAM, so they produce rsp_err=1 with rsp_data=0. There is no abort; the burst continues.
- RD_DRAIN:
  - When the last word is captured (edge E2+N-1), drive rsp_last=1 and req_ready=1 on that same edge, then return to IDLE.
  - A new request may therefore be accepted at edge E2+N.
- rsp_valid, rsp_last and rsp_err are single-cycle: cleared on the next edge unless a further word is delivered.
- ram_wea is never 1 during a read.
- ram_dina holds its last write value between writes.
- Requests presented while req_ready=0 are ignored (not queued). The requester must hold req_valid until accepted.
- There is no response backpressure: the consumer must accept every pulse.

Test Plan:
- Write then read: write addr 5, data 32'hDEADBEEF.
  - Write completion: rsp_valid+rsp_last 1 cycle after accept, rsp_err=0, ram_wea high exactly one cycle.
  - Read addr 5, len 1: rsp_data=DEADBEEF, rsp_err=0, rsp_last=1, 2 edges after accept.
- Burst read addr 10, len 4, RAM preloaded with word=addr: rsp_data 10,11,12,13 on 4 consecutive cycles starting 2 edges after accept; rsp_last only on 13; req_ready high on the same edge as the last response.
- Boundary and edge cases:
  - Read addr 126, len 4: responses for 126 and 127 have rsp_err=0; responses for 128 and 129 have rsp_data=0, rsp_err=1.
  - Read addr 20'hFFFFF, len 2: ram_addra wraps to 0.
- len=0 read at addr 3: exactly one response, rsp_last=1.
- Back-to-back: hold req_valid with a second read queued behind a len-2 burst; it is accepted at edge E2+2 with no idle gap.
- Assert rst_n low mid-burst (after the 2nd response of a len-8 burst): all outputs are 0 immediately except req_ready=1; no rsp_valid after release; the next request behaves normally.

Source files
------------

// File: rtl/ram_b_master_if.sv
// Request/response and RAM-port signals of the RAM_B initiator.
// The master modport is the initiator's view and the slave modport is the requester/RAM side.
interface ram_b_master_if #(
  parameter int ADDR_W = 20,
  parameter int LEN_W  = 5
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [LEN_W-1:0]  req_len;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_err;
  logic              rsp_last;
  logic              busy;
  logic [ADDR_W-1:0] ram_addra;
  logic              ram_wea;
  logic [31:0]       ram_dina;
  logic [47:0]       ram_douta;

  modport master (
    input  req_valid, req_we, req_addr, req_len, req_wdata, ram_douta,
    output req_ready, rsp_valid, rsp_data, rsp_err, rsp_last, busy,
           ram_addra, ram_wea, ram_dina
  );

  modport slave (
    output req_valid, req_we, req_addr, req_len, req_wdata, ram_douta,
    input  req_ready, rsp_valid, rsp_data, rsp_err, rsp_last, busy,
           ram_addra, ram_wea, ram_dina
  );
endinterface

// File: rtl/ram_b_master.sv
// Initiator for a RAM_B single-port memory that handles single-word writes and tag-checked burst reads.
// Read data returns two edges after each address is registered, so a 2-deep valid/last pipe tracks it.
//
// state    | meaning
// IDLE     | ready for a request
// WR       | write enable asserted for one cycle; the completion pulse follows
// RD_ISSUE | one read address per cycle until the last address has been presented
// RD_DRAIN | all addresses issued; waiting to capture the last word
module ram_b_master #(
  parameter logic [15:0] TAG    = 16'h0F37,
  parameter int          ADDR_W = 20,
  parameter int          LEN_W  = 5
) (
  input logic                clka,
  input logic                rst_n,
  ram_b_master_if.master     bus
);

  typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_DRAIN} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               w_accept;
  logic               w_issue;
  logic               w_wr_done;
  logic               w_capture;
  logic               w_cap_last;
  logic               w_len_one;
  logic [LEN_W-1:0]   w_len_eff;

  logic               r_ready;
  logic [ADDR_W-1:0]  r_addr;
  logic               r_wea;
  logic [31:0]        r_dina;
  logic [LEN_W-1:0]   r_remain;
  logic [1:0]         r_pipe_v;
  logic [1:0]         r_pipe_l;
  logic               r_rsp_valid;
  logic [31:0]        r_rsp_data;
  logic               r_rsp_err;
  logic               r_rsp_last;

  assign w_len_one  = (bus.req_len <= LEN_W'(1));
  assign w_len_eff  = (bus.req_len == '0) ? LEN_W'(1) : bus.req_len;
  assign w_capture  = r_pipe_v[1];
  assign w_cap_last = r_pipe_v[1] & r_pipe_l[1];

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_wr_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.req_valid && r_ready) begin
          w_accept = 1'b1;
          if (bus.req_we)     w_state_nxt = WR;
          else if (w_len_one) w_state_nxt = RD_DRAIN;
          else                w_state_nxt = RD_ISSUE;
        end
      end
      WR: begin
        w_wr_done   = 1'b1;
        w_state_nxt = IDLE;
      end
      RD_ISSUE: begin
        w_issue = 1'b1;
        if (r_remain == LEN_W'(1)) w_state_nxt = RD_DRAIN;
      end
      RD_DRAIN: begin
        if (w_cap_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge rst_n) begin
    if (!rst_n) begin
      r_ready     <= 1'b1;
      r_addr      <= '0;
      r_wea       <= 1'b0;
      r_dina      <= '0;
      r_remain    <= '0;
      r_pipe_v    <= '0;
      r_pipe_l    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_last  <= 1'b0;
    end else begin
      r_pipe_v    <= {r_pipe_v[0], 1'b0};
      r_pipe_l    <= {r_pipe_l[0], 1'b0};
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_rsp_last  <= 1'b0;

      if (w_accept) begin
        r_addr  <= bus.req_addr;
        r_ready <= 1'b0;
        if (bus.req_we) begin
          r_dina <= bus.req_wdata;
          r_wea  <= 1'b1;
        end else begin
          r_remain    <= w_len_eff - LEN_W'(1);
          r_pipe_v[0] <= 1'b1;
          r_pipe_l[0] <= w_len_one;
        end
      end

      // r_remain counts addresses still to issue; reaching 1 marks the burst's final address.
      if (w_issue) begin
        r_addr      <= r_addr + ADDR_W'(1);
        r_remain    <= r_remain - LEN_W'(1);
        r_pipe_v[0] <= 1'b1;
        r_pipe_l[0] <= (r_remain == LEN_W'(1));
      end

      if (w_wr_done) begin
        r_wea       <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_last  <= 1'b1;
        r_ready     <= 1'b1;
      end

      if (w_capture) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= bus.ram_douta[31:0];
        r_rsp_err   <= (bus.ram_douta[47:32] != TAG);
        r_rsp_last  <= r_pipe_l[1];
        if (r_pipe_l[1]) r_ready <= 1'b1;
      end
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.busy      = ~r_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_last  = r_rsp_last;
  assign bus.ram_addra = r_addr;
  assign bus.ram_wea   = r_wea;
  assign bus.ram_dina  = r_dina;

endmodule

// File: tb/tb_ram_b_master.sv
// Scoreboard bench for ram_b_master: directed requests push the expected responses and the cycle each should appear in.
// A negedge monitor pops and compares every response pulse; the RAM model holds 128 words preloaded with word = address.
module tb_ram_b_master;
  localparam int          ADDR_W = 20;
  localparam int          LEN_W  = 5;
  localparam logic [15:0] TAG    = 16'h0F37;

  typedef struct {
    logic [31:0] d;
    logic        e;
    logic        l;
    int          c;
  } exp_t;

  logic clka = 1'b0;
  logic rst_n = 1'b0;
  always #5 clka = ~clka;

  ram_b_master_if #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) bus();

  ram_b_master #(.TAG(TAG), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clka  (clka),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  logic [31:0] mem [0:127];
  logic        preloaded = 1'b0;
  always @(posedge clka) begin
    if (!preloaded) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'(i);
      preloaded      <= 1'b1;
      bus.ram_douta  <= '0;
    end else begin
      if (bus.ram_wea && bus.ram_addra < 20'd128) mem[bus.ram_addra[6:0]] <= bus.ram_dina;
      bus.ram_douta <= (bus.ram_addra < 20'd128) ? {TAG, mem[bus.ram_addra[6:0]]} : 48'b0;
    end
  end

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   wea_cyc = 0;
  exp_t sb [$];
  exp_t mon_x;

  always @(posedge clka) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_rsp(input logic [31:0] d, input logic e, input logic l, input int c);
    exp_t t;
    t.d = d; t.e = e; t.l = l; t.c = c;
    sb.push_back(t);
  endtask

  always @(negedge clka) begin
    if (rst_n) begin
      if (bus.ram_wea) wea_cyc++;
      if (bus.rsp_valid) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_rsp: got data %0h err %0b last %0b with nothing expected (cycle %0d)",
                   bus.rsp_data, bus.rsp_err, bus.rsp_last, cyc);
        end else begin
          mon_x = sb.pop_front();
          check("rsp_data",  bus.rsp_data, mon_x.d);
          check("rsp_err",   bus.rsp_err,  mon_x.e);
          check("rsp_last",  bus.rsp_last, mon_x.l);
          check("rsp_cycle", cyc,          mon_x.c);
          if (bus.rsp_last) check("ready_with_last", bus.req_ready, 1'b1);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge following the accept edge, with acc = accept-edge cycle.
  task automatic send(input logic we, input logic [19:0] addr, input logic [4:0] len,
                      input logic [31:0] wd, output int acc);
    int t = 0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.req_wdata = wd;
    while (!bus.req_ready && t < 100) begin
      @(negedge clka);
      t++;
    end
    if (!bus.req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, required 1", t);
      acc = -1;
    end else begin
      acc = cyc + 1;
      @(posedge clka);
      @(negedge clka);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    repeat (2) @(negedge clka);
    while ((sb.size() != 0 || !bus.req_ready) && t < 200) begin
      @(negedge clka);
      t++;
    end
    if (sb.size() != 0 || !bus.req_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL idle_timeout: %0d responses still pending, ready %0b, required 0 pending and ready 1",
               sb.size(), bus.req_ready);
    end
    repeat (3) @(negedge clka);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 1'b1);
    check({tag, "_busy"},      bus.busy,      1'b0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    check({tag, "_rsp_data"},  bus.rsp_data,  32'h0);
    check({tag, "_rsp_err"},   bus.rsp_err,   1'b0);
    check({tag, "_rsp_last"},  bus.rsp_last,  1'b0);
    check({tag, "_ram_addra"}, bus.ram_addra, 20'h0);
    check({tag, "_ram_wea"},   bus.ram_wea,   1'b0);
    check({tag, "_ram_dina"},  bus.ram_dina,  32'h0);
  endtask

  logic [31:0] bnd_d [4];
  logic        bnd_e [4];

  initial begin
    int a, a2;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.req_wdata = '0;
    bnd_d[0] = 32'd126; bnd_d[1] = 32'd127; bnd_d[2] = 32'd0; bnd_d[3] = 32'd0;
    bnd_e[0] = 1'b0;    bnd_e[1] = 1'b0;    bnd_e[2] = 1'b1;  bnd_e[3] = 1'b1;

    repeat (3) @(negedge clka);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clka);

    // Single write, then read it back.
    send(1'b1, 20'd5, 5'd0, 32'hDEADBEEF, a);
    expect_rsp(32'h0, 1'b0, 1'b1, a + 1);
    wait_idle();
    check("wea_one_cycle", wea_cyc, 1);
    check("dina_held", bus.ram_dina, 32'hDEADBEEF);

    send(1'b0, 20'd5, 5'd1, 32'h0, a);
    expect_rsp(32'hDEADBEEF, 1'b0, 1'b1, a + 2);
    wait_idle();

    // Burst of four from preloaded words.
    send(1'b0, 20'd10, 5'd4, 32'h0, a);
    for (int i = 0; i < 4; i++) expect_rsp(32'd10 + 32'(i), 1'b0, (i == 3), a + 2 + i);
    wait_idle();

    // Burst crossing the end of the populated range.
    send(1'b0, 20'd126, 5'd4, 32'h0, a);
    for (int i = 0; i < 4; i++) expect_rsp(bnd_d[i], bnd_e[i], (i == 3), a + 2 + i);
    wait_idle();

    // Address wrap from the top of the space.
    send(1'b0, 20'hFFFFF, 5'd2, 32'h0, a);
    expect_rsp(32'h0, 1'b1, 1'b0, a + 2);
    expect_rsp(32'h0, 1'b0, 1'b1, a + 3);
    check("addr_top", bus.ram_addra, 20'hFFFFF);
    @(negedge clka);
    check("addr_wrap", bus.ram_addra, 20'h0);
    wait_idle();

    // Zero length is a single word.
    send(1'b0, 20'd3, 5'd0, 32'h0, a);
    expect_rsp(32'd3, 1'b0, 1'b1, a + 2);
    wait_idle();
    repeat (5) @(negedge clka);

    // Second request held behind a two-word burst.
    send(1'b0, 20'd10, 5'd2, 32'h0, a);
    expect_rsp(32'd10, 1'b0, 1'b0, a + 2);
    expect_rsp(32'd11, 1'b0, 1'b1, a + 3);
    send(1'b0, 20'd20, 5'd1, 32'h0, a2);
    check("b2b_accept_cycle", a2, a + 4);
    expect_rsp(32'd20, 1'b0, 1'b1, a2 + 2);
    wait_idle();

    // Reset in the middle of an eight-word burst, after its second response.
    send(1'b0, 20'd40, 5'd8, 32'h0, a);
    for (int i = 0; i < 8; i++) expect_rsp(32'd40 + 32'(i), 1'b0, (i == 7), a + 2 + i);
    repeat (3) @(negedge clka);
    #2;
    check("pending_before_reset", sb.size(), 6);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check_reset_outputs("mid");
    repeat (2) @(negedge clka);
    #2 rst_n = 1'b1;
    repeat (10) @(negedge clka);

    send(1'b0, 20'd7, 5'd1, 32'h0, a);
    expect_rsp(32'd7, 1'b0, 1'b1, a + 2);
    wait_idle();

    check("wea_cycles_total", wea_cyc, 1);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before the test sequence ended");
    $fatal(1, "watchdog");
  end

endmodule
